// File: rtl/replacer_pkg.sv
// Shared token/state definitions for the replacer_compact encoder and replacer_extend decoder.
package replacer_pkg;

  localparam logic TOK_LIT = 1'b0;
  localparam logic TOK_RUN = 1'b1;
  localparam int   LEN_W   = 7;

  typedef struct packed {
    logic             tok_type;
    logic [LEN_W-1:0] len;
  } token_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LIT   = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  function automatic token_t make_tok(input logic t, input logic [LEN_W-1:0] n);
    token_t tk;
    tk.tok_type = t;
    tk.len      = n;
    return tk;
  endfunction

endpackage

// File: rtl/replacer_compact_if.sv
// Source-FIFO read port plus vid/cnt sink-FIFO write ports of the run-length encoder.
interface replacer_compact_if;
  import replacer_pkg::*;

  logic [7:0] data_in;
  logic       data_empty;
  logic       last_in;
  logic       data_rd;

  logic [7:0] vid_out;
  logic       vid_wr;
  logic       vid_afull;

  token_t     cnt_out;
  logic       cnt_wr;
  logic       cnt_afull;
  logic       last_sign_out;

  modport master (
    input  data_in, data_empty, last_in, vid_afull, cnt_afull,
    output data_rd, vid_out, vid_wr, cnt_out, cnt_wr, last_sign_out
  );

  modport slave (
    output data_in, data_empty, last_in, vid_afull, cnt_afull,
    input  data_rd, vid_out, vid_wr, cnt_out, cnt_wr, last_sign_out
  );

endinterface

// File: rtl/replacer_compact.sv
// Splits a byte stream into literal bytes (vid FIFO) and run/copy count tokens (cnt FIFO).
// Read at N -> byte at N+1 -> writes at N+2 (flush token N+3); reads stall on empty/afull/clk_en.
module replacer_compact
  import replacer_pkg::*;
#(
  parameter int MAX_LEN     = 127,
  parameter int AFULL_SLACK = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [7:0]         key,
  replacer_compact_if.master bus
);

  if (MAX_LEN < 1 || MAX_LEN > 127) begin : g_bad_max_len
    $error("replacer_compact: MAX_LEN must be within 1..127");
  end
  if (AFULL_SLACK < 2) begin : g_bad_slack
    $error("replacer_compact: AFULL_SLACK must cover in-flight byte plus flush token");
  end

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             flush_type_q, flush_type_d;
  logic [7:0]       key_q;
  logic             rd_vld_q;
  logic             vid_wr_q, vid_wr_d;
  logic [7:0]       vid_q, vid_d;
  logic             cnt_wr_q, cnt_wr_d;
  token_t           cnt_q, cnt_d;
  logic             last_q, last_d;

  logic [7:0]       key_eff;
  logic             is_key, cls, cur_type, in_run, same, pending;
  state_t           cls_state;
  logic [LEN_W-1:0] cnt_inc;

  // The key is only followed while idle so a frame is encoded against one value.
  assign key_eff   = (state_q == ST_IDLE) ? key : key_q;
  assign is_key    = (bus.data_in == key_eff);
  assign cls       = is_key ? TOK_RUN : TOK_LIT;
  assign cls_state = is_key ? ST_RUN : ST_LIT;
  assign cur_type  = (state_q == ST_RUN) ? TOK_RUN : TOK_LIT;
  assign in_run    = (state_q == ST_LIT) || (state_q == ST_RUN);
  assign same      = in_run && (cls == cur_type);
  assign pending   = in_run && (count_q != '0);
  assign cnt_inc   = count_q + ONE;

  assign bus.data_rd = rst & clk_en & ~bus.data_empty & ~bus.vid_afull & ~bus.cnt_afull
                     & (state_q != ST_FLUSH) & ~(rd_vld_q & bus.last_in);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    flush_type_d = flush_type_q;
    vid_wr_d     = 1'b0;
    vid_d        = vid_q;
    cnt_wr_d     = 1'b0;
    cnt_d        = cnt_q;
    last_d       = 1'b0;

    if (state_q == ST_FLUSH) begin
      cnt_wr_d = 1'b1;
      cnt_d    = make_tok(flush_type_q, ONE);
      last_d   = 1'b1;
      count_d  = '0;
      state_d  = ST_IDLE;
    end else if (rd_vld_q) begin
      if (!is_key) begin
        vid_wr_d = 1'b1;
        vid_d    = bus.data_in;
      end
      if (same) begin
        if (bus.last_in || cnt_inc == MAX_L) begin
          cnt_wr_d = 1'b1;
          cnt_d    = make_tok(cls, cnt_inc);
          last_d   = bus.last_in;
          count_d  = '0;
          state_d  = bus.last_in ? ST_IDLE : state_q;
        end else begin
          count_d = cnt_inc;
        end
      end else if (pending) begin
        // Closing the old run uses this cycle's token slot; a final byte waits in FLUSH.
        cnt_wr_d = 1'b1;
        cnt_d    = make_tok(cur_type, count_q);
        if (bus.last_in) begin
          flush_type_d = cls;
          count_d      = '0;
          state_d      = ST_FLUSH;
        end else begin
          count_d = ONE;
          state_d = cls_state;
        end
      end else if (bus.last_in || MAX_L == ONE) begin
        cnt_wr_d = 1'b1;
        cnt_d    = make_tok(cls, ONE);
        last_d   = bus.last_in;
        count_d  = '0;
        state_d  = bus.last_in ? ST_IDLE : cls_state;
      end else begin
        count_d = ONE;
        state_d = cls_state;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      flush_type_q <= TOK_LIT;
      key_q        <= '0;
      rd_vld_q     <= 1'b0;
      vid_wr_q     <= 1'b0;
      vid_q        <= '0;
      cnt_wr_q     <= 1'b0;
      cnt_q        <= '0;
      last_q       <= 1'b0;
    end else if (clk_en) begin
      state_q      <= state_d;
      count_q      <= count_d;
      flush_type_q <= flush_type_d;
      if (state_q == ST_IDLE) key_q <= key;
      rd_vld_q     <= bus.data_rd;
      vid_wr_q     <= vid_wr_d;
      vid_q        <= vid_d;
      cnt_wr_q     <= cnt_wr_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
    end
  end

  // A masked strobe is held, not lost: the sink only consumes it on an enabled edge.
  assign bus.vid_wr        = vid_wr_q & clk_en;
  assign bus.vid_out       = vid_q;
  assign bus.cnt_wr        = cnt_wr_q & clk_en;
  assign bus.cnt_out       = cnt_q;
  assign bus.last_sign_out = last_q & clk_en;

endmodule
